// File: rtl/cpu_trace_buffer_pkg.sv
// Shared constants for the cpu trace buffer: FSM encoding and entry layout.
// Each entry is packed as {pc, wb, sreg}, with sreg in the low byte.
package cpu_trace_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMED     = 2'd1;
    localparam logic [1:0] ST_TRIGGERED = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam int SREG_W        = 8;
    localparam int DEF_I_ADDR_W  = 10;
    localparam int DEF_DATA_W    = 8;
    localparam int ENTRY_W       = DEF_I_ADDR_W + DEF_DATA_W + SREG_W;

    function automatic int entry_width(input int iw, input int dw);
        return iw + dw + SREG_W;
    endfunction

    function automatic int sreg_lsb();
        return 0;
    endfunction

    function automatic int wb_lsb();
        return SREG_W;
    endfunction

    function automatic int pc_lsb(input int dw);
        return SREG_W + dw;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Sample and readback bus between the cpu debug outputs and the trace buffer.
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int I_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int PTR_WIDTH    = 4
);
    logic                    smp_valid;
    logic [I_ADDR_WIDTH-1:0] smp_pc;
    logic [DATA_WIDTH-1:0]   smp_wb;
    logic [SREG_W-1:0]       smp_sreg;

    logic                    rd_en;
    logic [PTR_WIDTH-1:0]    rd_idx;
    logic                    rd_valid;
    logic [I_ADDR_WIDTH-1:0] rd_pc;
    logic [DATA_WIDTH-1:0]   rd_wb;
    logic [SREG_W-1:0]       rd_sreg;

    modport master (
        output smp_valid, smp_pc, smp_wb, smp_sreg, rd_en, rd_idx,
        input  rd_valid, rd_pc, rd_wb, rd_sreg
    );

    modport slave (
        input  smp_valid, smp_pc, smp_wb, smp_sreg, rd_en, rd_idx,
        output rd_valid, rd_pc, rd_wb, rd_sreg
    );
endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A same-address read and write returns the previous contents.
module trace_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 26
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rq
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) rq <= mem[ra];
    end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction trace capture: circular buffer of retired-instruction samples
// with a PC-match trigger, post-trigger window and readback by age index.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int I_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int PTR_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    stop,
    input  logic [I_ADDR_WIDTH-1:0] trig_pc,
    input  logic [PTR_WIDTH:0]      post_count,
    output logic [1:0]              state,
    output logic [PTR_WIDTH:0]      count,
    output logic                    overflow,
    cpu_trace_buffer_if.slave       bus
);
    localparam int ENT_W   = entry_width(I_ADDR_WIDTH, DATA_WIDTH);
    localparam int PC_LSB  = pc_lsb(DATA_WIDTH);
    localparam int WB_LSB  = wb_lsb();
    localparam int SR_LSB  = sreg_lsb();
    localparam logic [PTR_WIDTH:0] FULL     = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] POST_MAX = (PTR_WIDTH+1)'(DEPTH-1);

    logic [1:0]           state_reg, state_next;
    logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH:0]   count_reg, count_next;
    logic [PTR_WIDTH-1:0] post_reg, post_next;
    logic                 overflow_reg, overflow_next;
    logic                 rd_valid_reg, rd_hit_reg;

    logic                 capturing, wr_en, trig_hit;
    logic [PTR_WIDTH-1:0] post_clamped, rd_addr;
    logic [ENT_W-1:0]     wr_data, rd_data;

    assign capturing    = (state_reg == ST_ARMED) || (state_reg == ST_TRIGGERED);
    // A restart via arm discards whatever sample arrives alongside it.
    assign wr_en        = bus.smp_valid && capturing && !arm;
    assign trig_hit     = wr_en && (state_reg == ST_ARMED) && (bus.smp_pc == trig_pc);
    assign post_clamped = (post_count > POST_MAX) ? POST_MAX[PTR_WIDTH-1:0]
                                                  : post_count[PTR_WIDTH-1:0];
    assign wr_data      = {bus.smp_pc, bus.smp_wb, bus.smp_sreg};

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        post_next     = post_reg;
        overflow_next = overflow_reg;
        if (arm) begin
            state_next    = ST_ARMED;
            wr_ptr_next   = '0;
            count_next    = '0;
            post_next     = '0;
            overflow_next = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
                if (count_reg == FULL) overflow_next = 1'b1;
                else                   count_next    = count_reg + 1'b1;
            end
            case (state_reg)
                ST_ARMED: begin
                    if (trig_hit) begin
                        if (post_clamped == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_TRIGGERED;
                            post_next  = post_clamped;
                        end
                    end
                end
                ST_TRIGGERED: begin
                    if (wr_en) begin
                        post_next = post_reg - 1'b1;
                        if (post_reg == 1) state_next = ST_DONE;
                    end
                end
                default: ;
            endcase
            if (stop && capturing) state_next = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            post_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            post_reg     <= post_next;
            overflow_reg <= overflow_next;
        end
    end

    // Oldest entry sits count slots behind the write pointer; a full count
    // truncates to zero, which lands exactly on the write pointer.
    assign rd_addr = wr_ptr_reg - count_reg[PTR_WIDTH-1:0] + bus.rd_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) rd_hit_reg <= ({1'b0, bus.rd_idx} < count_reg);
        end
    end

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_WIDTH),
        .DATA_W (ENT_W)
    ) u_ram (
        .clk (clk),
        .we  (wr_en),
        .wa  (wr_ptr_reg),
        .wd  (wr_data),
        .re  (bus.rd_en),
        .ra  (rd_addr),
        .rq  (rd_data)
    );

    // The RAM word is unreset, so the hit flag gates it to zero after reset
    // and for out-of-range indices; both only change on a read request.
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_pc    = rd_hit_reg ? rd_data[PC_LSB +: I_ADDR_WIDTH] : '0;
    assign bus.rd_wb    = rd_hit_reg ? rd_data[WB_LSB +: DATA_WIDTH]   : '0;
    assign bus.rd_sreg  = rd_hit_reg ? rd_data[SR_LSB +: SREG_W]       : '0;

    assign state    = state_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;
endmodule
